// File: rtl/servo_pwm_driver.sv
// Pan/tilt hobby-servo PWM generator with per-frame slew limiting and a laser
// gate that only opens once both servos have reached the sampled target.
module servo_pwm_driver #(
  parameter int unsigned clock_frequency_mhz = 50,
  parameter int unsigned frame_us            = 20000,
  parameter int unsigned pan_base_us         = 1180,
  parameter int unsigned tilt_base_us        = 1260,
  parameter int unsigned max_step_us         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] coord_x,
  input  logic [8:0] coord_y,
  input  logic       fire,
  output logic       pwm_pan,
  output logic       pwm_tilt,
  output logic       laser_en,
  output logic       frame_start
);

  localparam int unsigned PW = (clock_frequency_mhz > 1) ? $clog2(clock_frequency_mhz) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(clock_frequency_mhz - 1);
  localparam logic [14:0]   US_MAX    = 15'(frame_us - 1);
  localparam logic [14:0]   STEP      = 15'(max_step_us);
  localparam logic [14:0]   PAN_CTR   = 15'(pan_base_us + 320);
  localparam logic [14:0]   TILT_CTR  = 15'(tilt_base_us + 240);

  typedef enum logic {SLEWING, SETTLED} slew_state_e;

  logic [PW-1:0] presc_q, presc_d;
  logic [14:0]   us_count_q, us_count_d;
  logic [14:0]   pan_tgt_q, pan_tgt_d, tilt_tgt_q, tilt_tgt_d;
  logic [14:0]   pan_w_q, pan_w_d, tilt_w_q, tilt_w_d;
  logic          pwm_pan_q, pwm_pan_d, pwm_tilt_q, pwm_tilt_d;
  logic          laser_q, laser_d, frame_start_q, frame_start_d;
  logic          us_tick, boundary;
  logic [9:0]    x_clamp;
  logic [8:0]    y_clamp;
  slew_state_e   slew_state;

  // Move cur toward tgt by at most STEP, landing exactly on tgt when close.
  function automatic logic [14:0] slew(input logic [14:0] cur, input logic [14:0] tgt);
    if (tgt >= cur) return ((tgt - cur) <= STEP) ? tgt : cur + STEP;
    else            return ((cur - tgt) <= STEP) ? tgt : cur - STEP;
  endfunction

  always_comb begin
    us_tick    = (presc_q == PRESC_MAX);
    boundary   = us_tick && (us_count_q == US_MAX);
    presc_d    = us_tick ? '0 : presc_q + PW'(1);
    us_count_d = us_count_q;
    if (us_tick) us_count_d = (us_count_q == US_MAX) ? '0 : us_count_q + 15'd1;

    x_clamp    = (coord_x > 10'd639) ? 10'd639 : coord_x;
    y_clamp    = (coord_y > 9'd479)  ? 9'd479  : coord_y;
    pan_tgt_d  = pan_tgt_q;
    tilt_tgt_d = tilt_tgt_q;
    pan_w_d    = pan_w_q;
    tilt_w_d   = tilt_w_q;
    if (boundary) begin
      pan_tgt_d  = 15'(pan_base_us)  + {5'd0, x_clamp};
      tilt_tgt_d = 15'(tilt_base_us) + {6'd0, y_clamp};
      pan_w_d    = slew(pan_w_q,  pan_tgt_d);
      tilt_w_d   = slew(tilt_w_q, tilt_tgt_d);
    end

    slew_state = ((pan_w_q == pan_tgt_q) && (tilt_w_q == tilt_tgt_q)) ? SETTLED : SLEWING;

    pwm_pan_d     = (us_count_q < pan_w_q);
    pwm_tilt_d    = (us_count_q < tilt_w_q);
    laser_d       = fire && (slew_state == SETTLED);
    frame_start_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      us_count_q    <= '0;
      pan_tgt_q     <= PAN_CTR;
      tilt_tgt_q    <= TILT_CTR;
      pan_w_q       <= PAN_CTR;
      tilt_w_q      <= TILT_CTR;
      pwm_pan_q     <= 1'b0;
      pwm_tilt_q    <= 1'b0;
      laser_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      us_count_q    <= us_count_d;
      pan_tgt_q     <= pan_tgt_d;
      tilt_tgt_q    <= tilt_tgt_d;
      pan_w_q       <= pan_w_d;
      tilt_w_q      <= tilt_w_d;
      pwm_pan_q     <= pwm_pan_d;
      pwm_tilt_q    <= pwm_tilt_d;
      laser_q       <= laser_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pwm_pan     = pwm_pan_q;
  assign pwm_tilt    = pwm_tilt_q;
  assign laser_en    = laser_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Randomized bench for servo_pwm_driver against a cycle-count based reference
// model; a shorter frame and larger step keep the run compact.
module tb_servo_pwm_driver;

  localparam int CLK_MHZ    = 2;
  localparam int FRAME      = 2000;
  localparam int PAN_BASE   = 1180;
  localparam int TILT_BASE  = 1260;
  localparam int STEP       = 64;
  localparam int FRAME_CLKS = CLK_MHZ * FRAME;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] coord_x;
  logic [8:0] coord_y;
  logic       fire;
  logic       pwm_pan, pwm_tilt, laser_en, frame_start;
  logic       chk_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  servo_pwm_driver #(
    .clock_frequency_mhz(CLK_MHZ),
    .frame_us           (FRAME),
    .pan_base_us        (PAN_BASE),
    .tilt_base_us       (TILT_BASE),
    .max_step_us        (STEP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coord_x    (coord_x),
    .coord_y    (coord_y),
    .fire       (fire),
    .pwm_pan    (pwm_pan),
    .pwm_tilt   (pwm_tilt),
    .laser_en   (laser_en),
    .frame_start(frame_start)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int slew_to(int w, int t);
    if (t - w > STEP)  return w + STEP;
    if (w - t > STEP)  return w - STEP;
    return t;
  endfunction

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  // Reference: position in the frame follows directly from edges since reset.
  int   cyc;
  int   m_pan_w, m_tilt_w, m_pan_t, m_tilt_t;
  logic exp_pan, exp_tilt, exp_laser, exp_fs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc       <= 0;
      m_pan_w   <= PAN_BASE + 320;
      m_pan_t   <= PAN_BASE + 320;
      m_tilt_w  <= TILT_BASE + 240;
      m_tilt_t  <= TILT_BASE + 240;
      exp_pan   <= 1'b0;
      exp_tilt  <= 1'b0;
      exp_laser <= 1'b0;
      exp_fs    <= 1'b0;
    end else begin
      exp_pan   <= ((cyc / CLK_MHZ) % FRAME) < m_pan_w;
      exp_tilt  <= ((cyc / CLK_MHZ) % FRAME) < m_tilt_w;
      exp_laser <= fire && (m_pan_w == m_pan_t) && (m_tilt_w == m_tilt_t);
      exp_fs    <= ((cyc + 1) % FRAME_CLKS) == 0;
      if (((cyc + 1) % FRAME_CLKS) == 0) begin
        m_pan_t  <= PAN_BASE + min_i(int'(coord_x), 639);
        m_tilt_t <= TILT_BASE + min_i(int'(coord_y), 479);
        m_pan_w  <= slew_to(m_pan_w, PAN_BASE + min_i(int'(coord_x), 639));
        m_tilt_w <= slew_to(m_tilt_w, TILT_BASE + min_i(int'(coord_y), 479));
      end
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("pwm_pan",     pwm_pan,     exp_pan);
      check_eq("pwm_tilt",    pwm_tilt,    exp_tilt);
      check_eq("laser_en",    laser_en,    exp_laser);
      check_eq("frame_start", frame_start, exp_fs);
    end
  end

  task automatic wait_frame();
    int n = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && n < 2 * FRAME_CLKS) begin
      @(negedge clk);
      n++;
    end
    check_eq("frame_seen", frame_start, 1);
  endtask

  task automatic measure(output int hp, output int ht);
    wait_frame();
    hp = 0;
    ht = 0;
    repeat (FRAME_CLKS) begin
      @(negedge clk);
      if (pwm_pan === 1'b1)  hp++;
      if (pwm_tilt === 1'b1) ht++;
    end
  endtask

  int hp, ht;

  initial begin
    rst_n   = 1'b0;
    coord_x = 10'd320;
    coord_y = 9'd240;
    fire    = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("pan_rise_after_reset", pwm_pan, 1);

    // Centre position: 1500 us pulses.
    measure(hp, ht);
    check_eq("centre_pan_clks",  hp, 1500 * CLK_MHZ);
    check_eq("centre_tilt_clks", ht, 1500 * CLK_MHZ);

    // Out-of-range coordinates clamp; laser held off while slewing.
    coord_x = 10'd1000;
    coord_y = 9'd511;
    fire    = 1'b1;
    wait_frame();
    repeat (2) @(negedge clk);
    check_eq("laser_blocked_slewing", laser_en, 0);
    repeat (4) wait_frame();
    measure(hp, ht);
    check_eq("clamp_pan_clks",  hp, 1819 * CLK_MHZ);
    check_eq("clamp_tilt_clks", ht, 1739 * CLK_MHZ);
    check_eq("laser_settled", laser_en, 1);
    fire = 1'b0;
    @(negedge clk);
    check_eq("laser_drop", laser_en, 0);

    // Mid-frame coordinate glitch is ignored; held value is taken at boundary.
    wait_frame();
    repeat (1000) @(negedge clk);
    coord_y = 9'd0;
    repeat (200) @(negedge clk);
    coord_y = 9'd511;
    wait_frame();
    coord_y = 9'd0;
    wait_frame();

    // Random coordinate and fire activity.
    for (int i = 0; i < 5 * FRAME_CLKS; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 599) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          coord_x = 10'($urandom_range(0, 1023));
          coord_y = 9'($urandom_range(0, 511));
        end else begin
          coord_x = 10'($urandom_range(280, 360));
          coord_y = 9'($urandom_range(200, 280));
        end
      end
      if ($urandom_range(0, 299) == 0) fire = ~fire;
    end

    // Asynchronous reset in the middle of a pulse.
    coord_x = 10'd0;
    coord_y = 9'd0;
    wait_frame();
    repeat (200) @(negedge clk);
    check_eq("pwm_pan_midpulse", pwm_pan, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_pwm_pan",     pwm_pan,     0);
    check_eq("rst_pwm_tilt",    pwm_tilt,    0);
    check_eq("rst_laser_en",    laser_en,    0);
    check_eq("rst_frame_start", frame_start, 0);
    coord_x = 10'd320;
    coord_y = 9'd240;
    fire    = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("laser_settled_after_reset", laser_en, 1);
    measure(hp, ht);
    check_eq("post_reset_pan_clks",  hp, 1500 * CLK_MHZ);
    check_eq("post_reset_tilt_clks", ht, 1500 * CLK_MHZ);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
